// File: rtl/acc_mr_muldiv.sv
// Sequential multiply/divide unit. It runs a WIDTH-cycle shift-add multiply or a
// restoring divide on operand magnitudes, then applies sign correction into ACC (high/remainder) and MR (low/quotient).

module acc_mr_muldiv #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_a;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_acc_out;
  logic [WIDTH-1:0] r_mr_out;
  logic             r_done;
  logic             r_div_zero;

  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = SIGNED_EN && op[0];
  assign w_sa     = w_signed && a[WIDTH-1];
  assign w_sb     = w_signed && b[WIDTH-1];
  assign w_a_mag  = w_sa ? -a : a;
  assign w_b_mag  = w_sb ? -b : b;

  // Multiply step: conditionally add the multiplicand, then shift {hi,lo} right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

  // Divide step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opnd});
  assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quot     = r_neg_q ? -r_lo : r_lo;
  assign w_rem      = r_neg_r ? -r_hi : r_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_a        <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_acc_out  <= '0;
      r_mr_out   <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_a        <= a;
            r_is_div   <= op[1];
            r_dz       <= op[1] && (b == '0);
            r_div_zero <= 1'b0;
            r_neg_q    <= w_sa ^ w_sb;
            r_neg_r    <= op[1] && w_sa;
            // MUL keeps the multiplier in lo; DIV keeps the dividend in lo, divisor in opnd.
            r_lo       <= op[1] ? w_a_mag : w_b_mag;
            r_opnd     <= op[1] ? w_b_mag : w_a_mag;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_is_div) begin
            r_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_is_div && r_dz) begin
            r_acc_out  <= r_a;
            r_mr_out   <= '1;
            r_div_zero <= 1'b1;
          end else if (r_is_div) begin
            r_acc_out <= w_rem;
            r_mr_out  <= w_quot;
          end else begin
            r_acc_out <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_mr_out  <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign acc_out  = r_acc_out;
  assign mr_out   = r_mr_out;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_acc_mr_muldiv.sv
// Testbench for acc_mr_muldiv. A signed and an unsigned-only instance run side by side
// and are compared against an arithmetic reference model.

module tb_acc_mr_muldiv;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         busy, done, divZero;
  logic [W-1:0] accOut, mrOut;
  logic         busyU, doneU, divZeroU;
  logic [W-1:0] accOutU, mrOutU;

  int checks = 0;
  int passes = 0;

  acc_mr_muldiv #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .acc_out(accOut), .mr_out(mrOut), .div_zero(divZero)
  );

  acc_mr_muldiv #(.WIDTH(W), .SIGNED_EN(1'b0)) dutU (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busyU), .done(doneU), .acc_out(accOutU), .mr_out(mrOutU), .div_zero(divZeroU)
  );

  always #5 clk = ~clk;

  // Reference result {div_zero, acc, mr} from plain integer arithmetic.
  function automatic logic [2*W:0] model(input bit sgnEn, input logic [1:0] opIn,
                                         input logic [W-1:0] aIn, input logic [W-1:0] bIn);
    longint va, vb, res, quo, rem;
    bit sgn;
    sgn = sgnEn && opIn[0];
    va  = sgn ? longint'($signed(aIn)) : longint'(aIn);
    vb  = sgn ? longint'($signed(bIn)) : longint'(bIn);
    if (!opIn[1]) begin
      res = va * vb;
      return {1'b0, res[2*W-1:0]};
    end
    if (bIn == '0) return {1'b1, aIn, {W{1'b1}}};
    quo = va / vb;
    rem = va % vb;
    return {1'b0, rem[W-1:0], quo[W-1:0]};
  endfunction

  // Launches one operation and waits (bounded) for done; operands are scrambled while busy.
  task automatic do_op(input logic [1:0] opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                       input bit immediate, output int lat, output int busyCnt,
                       output bit held, output bit dz1);
    logic [W-1:0] accPrev, mrPrev;
    if (!immediate) @(negedge clk);
    op = opIn; a = aIn; b = bIn; start = 1'b1;
    accPrev = accOut; mrPrev = mrOut;
    @(posedge clk);
    #1 start = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 0; busyCnt = 0; held = 1'b1;
    @(negedge clk);
    dz1 = divZero;
    while (!done && lat < 40) begin
      if (busy) busyCnt++;
      if (accOut !== accPrev || mrOut !== mrPrev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, divZero, accOut, mrOut} !== '0)
      $display("[TB] FAIL reset_state: got %h required 0", {busy, done, divZero, accOut, mrOut});
    else passes++;
    checks++;
    if ({busyU, doneU, divZeroU, accOutU, mrOutU} !== '0)
      $display("[TB] FAIL reset_state_u: got %h required 0", {busyU, doneU, divZeroU, accOutU, mrOutU});
    else passes++;
    rst = 1'b1;
  endtask

  task automatic test_mul();
    logic [W-1:0] aList[3] = '{16'hFFFF, 16'hFFFD, 16'h8000};
    logic [W-1:0] bList[3] = '{16'hFFFF, 16'h0005, 16'h8000};
    logic [1:0] opList[3]  = '{2'b00, 2'b01, 2'b01};
    int lat, busyCnt;
    bit held, dz1;
    logic [2*W:0] exp, expU;
    for (int i = 0; i < 3; i++) begin
      do_op(opList[i], aList[i], bList[i], 1'b0, lat, busyCnt, held, dz1);
      exp  = model(1'b1, opList[i], aList[i], bList[i]);
      expU = model(1'b0, opList[i], aList[i], bList[i]);
      checks++;
      if (lat != W + 1) $display("[TB] FAIL mul_latency: got %0d required %0d", lat, W + 1);
      else passes++;
      checks++;
      if (busyCnt != W + 1) $display("[TB] FAIL mul_busy_cycles: got %0d required %0d", busyCnt, W + 1);
      else passes++;
      checks++;
      if (!held) $display("[TB] FAIL mul_hold: outputs changed while busy, required held");
      else passes++;
      checks++;
      if ({divZero, accOut, mrOut} !== exp)
        $display("[TB] FAIL mul_result: got %h required %h", {divZero, accOut, mrOut}, exp);
      else passes++;
      checks++;
      if ({divZeroU, accOutU, mrOutU} !== expU)
        $display("[TB] FAIL mul_result_u: got %h required %h", {divZeroU, accOutU, mrOutU}, expU);
      else passes++;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) $display("[TB] FAIL mul_done_pulse: got %b required 0", done);
      else passes++;
    end
  endtask

  task automatic test_div();
    logic [W-1:0] aList[3] = '{16'd100, 16'hFFF9, 16'h8000};
    logic [W-1:0] bList[3] = '{16'd7, 16'h0002, 16'hFFFF};
    logic [1:0] opList[3]  = '{2'b10, 2'b11, 2'b11};
    int lat, busyCnt;
    bit held, dz1;
    logic [2*W:0] exp, expU;
    for (int i = 0; i < 3; i++) begin
      do_op(opList[i], aList[i], bList[i], 1'b0, lat, busyCnt, held, dz1);
      exp  = model(1'b1, opList[i], aList[i], bList[i]);
      expU = model(1'b0, opList[i], aList[i], bList[i]);
      checks++;
      if (lat != W + 1) $display("[TB] FAIL div_latency: got %0d required %0d", lat, W + 1);
      else passes++;
      checks++;
      if ({divZero, accOut, mrOut} !== exp)
        $display("[TB] FAIL div_result: got %h required %h", {divZero, accOut, mrOut}, exp);
      else passes++;
      checks++;
      if ({divZeroU, accOutU, mrOutU} !== expU)
        $display("[TB] FAIL div_result_u: got %h required %h", {divZeroU, accOutU, mrOutU}, expU);
      else passes++;
    end
  endtask

  task automatic test_div_zero();
    int lat, busyCnt;
    bit held, dz1;
    do_op(2'b10, 16'h1234, 16'h0000, 1'b0, lat, busyCnt, held, dz1);
    checks++;
    if (lat != W + 1) $display("[TB] FAIL divzero_latency: got %0d required %0d", lat, W + 1);
    else passes++;
    checks++;
    if ({divZero, accOut, mrOut} !== {1'b1, 16'h1234, 16'hFFFF})
      $display("[TB] FAIL divzero_result: got %h required %h", {divZero, accOut, mrOut}, {1'b1, 16'h1234, 16'hFFFF});
    else passes++;
    do_op(2'b11, 16'h8765, 16'h0000, 1'b0, lat, busyCnt, held, dz1);
    checks++;
    if (dz1 !== 1'b0) $display("[TB] FAIL divzero_clear: got %b required 0", dz1);
    else passes++;
    checks++;
    if ({divZero, accOut, mrOut} !== model(1'b1, 2'b11, 16'h8765, 16'h0000))
      $display("[TB] FAIL divzero_signed: got %h required %h", {divZero, accOut, mrOut}, model(1'b1, 2'b11, 16'h8765, 16'h0000));
    else passes++;
    do_op(2'b00, 16'h0002, 16'h0003, 1'b0, lat, busyCnt, held, dz1);
    checks++;
    if ({dz1, divZero} !== 2'b00) $display("[TB] FAIL divzero_after_mul: got %b required 00", {dz1, divZero});
    else passes++;
  endtask

  task automatic test_ignore_start();
    int lat;
    bit sawBusy;
    @(negedge clk);
    op = 2'b00; a = 16'h0123; b = 16'h0456; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1; op = 2'b10; a = W'($urandom); b = W'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != W + 1) $display("[TB] FAIL ignore_latency: got %0d required %0d", lat, W + 1);
    else passes++;
    checks++;
    if ({divZero, accOut, mrOut} !== model(1'b1, 2'b00, 16'h0123, 16'h0456))
      $display("[TB] FAIL ignore_result: got %h required %h", {divZero, accOut, mrOut}, model(1'b1, 2'b00, 16'h0123, 16'h0456));
    else passes++;
    sawBusy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
    end
    checks++;
    if (sawBusy) $display("[TB] FAIL ignore_no_queue: got busy=1 required idle");
    else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, busyCnt;
    bit held, dz1;
    do_op(2'b11, 16'hFFF9, 16'h0002, 1'b0, lat, busyCnt, held, dz1);
    checks++;
    if ({accOut, mrOut} !== 32'hFFFF_FFFD)
      $display("[TB] FAIL b2b_first: got %h required %h", {accOut, mrOut}, 32'hFFFF_FFFD);
    else passes++;
    do_op(2'b10, 16'd100, 16'd7, 1'b1, lat, busyCnt, held, dz1);
    checks++;
    if (lat != W + 1) $display("[TB] FAIL b2b_latency: got %0d required %0d", lat, W + 1);
    else passes++;
    checks++;
    if (busyCnt != W + 1) $display("[TB] FAIL b2b_busy_cycles: got %0d required %0d", busyCnt, W + 1);
    else passes++;
    checks++;
    if ({divZero, accOut, mrOut} !== model(1'b1, 2'b10, 16'd100, 16'd7))
      $display("[TB] FAIL b2b_second: got %h required %h", {divZero, accOut, mrOut}, model(1'b1, 2'b10, 16'd100, 16'd7));
    else passes++;
  endtask

  task automatic test_reset_mid_op();
    int lat, busyCnt;
    bit held, dz1, sawDone;
    @(negedge clk);
    op = 2'b00; a = 16'h1234; b = 16'h4321; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, divZero, accOut, mrOut} !== '0)
      $display("[TB] FAIL midreset_clear: got %h required 0", {busy, done, divZero, accOut, mrOut});
    else passes++;
    checks++;
    if ({busyU, doneU, divZeroU, accOutU, mrOutU} !== '0)
      $display("[TB] FAIL midreset_clear_u: got %h required 0", {busyU, doneU, divZeroU, accOutU, mrOutU});
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sawDone = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || doneU || busy) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) $display("[TB] FAIL midreset_no_done: got activity after abort, required none");
    else passes++;
    do_op(2'b00, 16'd3, 16'd4, 1'b0, lat, busyCnt, held, dz1);
    checks++;
    if ({accOut, mrOut} !== 32'h0000_000C)
      $display("[TB] FAIL midreset_fresh: got %h required %h", {accOut, mrOut}, 32'h0000_000C);
    else passes++;
  endtask

  task automatic test_unsigned_mode();
    int lat, busyCnt;
    bit held, dz1;
    do_op(2'b01, 16'hFFFD, 16'h0005, 1'b0, lat, busyCnt, held, dz1);
    checks++;
    if ({accOutU, mrOutU} !== 32'h0004_FFF1)
      $display("[TB] FAIL unsigned_mul: got %h required %h", {accOutU, mrOutU}, 32'h0004_FFF1);
    else passes++;
    checks++;
    if ({accOut, mrOut} !== 32'hFFFF_FFF1)
      $display("[TB] FAIL signed_mul_ref: got %h required %h", {accOut, mrOut}, 32'hFFFF_FFF1);
    else passes++;
    do_op(2'b11, 16'hFFF9, 16'h0002, 1'b0, lat, busyCnt, held, dz1);
    checks++;
    if ({divZeroU, accOutU, mrOutU} !== model(1'b0, 2'b10, 16'hFFF9, 16'h0002))
      $display("[TB] FAIL unsigned_div: got %h required %h", {divZeroU, accOutU, mrOutU}, model(1'b0, 2'b10, 16'hFFF9, 16'h0002));
    else passes++;
  endtask

  task automatic test_random();
    int lat, busyCnt;
    bit held, dz1;
    logic [1:0] rOp;
    logic [W-1:0] rA, rB;
    logic [2*W:0] exp, expU;
    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = W'($urandom);
      rB  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (i % 6 == 5) rA = 16'h8000;
      do_op(rOp, rA, rB, (i % 2) == 1, lat, busyCnt, held, dz1);
      exp  = model(1'b1, rOp, rA, rB);
      expU = model(1'b0, rOp, rA, rB);
      checks++;
      if (lat != W + 1 || busyCnt != W + 1)
        $display("[TB] FAIL rand_timing: got lat=%0d busy=%0d required %0d", lat, busyCnt, W + 1);
      else passes++;
      checks++;
      if ({divZero, accOut, mrOut} !== exp)
        $display("[TB] FAIL rand_result op=%b a=%h b=%h: got %h required %h", rOp, rA, rB, {divZero, accOut, mrOut}, exp);
      else passes++;
      checks++;
      if ({divZeroU, accOutU, mrOutU} !== expU)
        $display("[TB] FAIL rand_result_u op=%b a=%h b=%h: got %h required %h", rOp, rA, rB, {divZeroU, accOutU, mrOutU}, expU);
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    test_unsigned_mode();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
